fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain.
- Drives the FIFO's rinc from its rempty status.
- Absorbs the RAM's one-cycle registered read latency.
- Presents the data as a valid/ready stream through a 2-entry output buffer.
- Sustains one word per cycle when the downstream is always ready.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- rclk  input  1  read-domain clock; all logic on posedge.
- rrstn  input  1  asynchronous active-low reset.
- rempty  input  1  FIFO empty flag. When high, the FIFO ignores rinc.
- rdata  input  WIDTH  FIFO read data. Valid in the cycle after an accepted read.
- rinc  output  1  read request to the FIFO.
- flush  input  1  synchronous discard of all buffered and in-flight words.
- m_ready  input  1  downstream ready.
- m_valid  output  1  output word valid.
- m_data  output  WIDTH  output word (buffer head).
- word_cnt  output  CNT_WIDTH  number of words delivered on the stream. Wraps modulo 2^CNT_WIDTH.

Behaviour:
- Clock/reset: single clock rclk. Reset rrstn is asynchronous, active-low.
- Reset values:
  - rinc=0 (combinational, forced low while rrstn low), m_valid=0, m_data=0, word_cnt=0.
  - Buffer occupancy occ=0, in-flight flag inflight=0, drop flag=0.
- Read acceptance: a read is accepted in cycle T when rinc && !rempty.
  - inflight is set for cycle T+1.
  - In cycle T+1, rdata is written into the buffer tail at the end of the cycle, unless the drop flag is set.
- rinc (combinational) = !rempty && !flush && (occ + inflight - pop) < 2, where pop = m_valid && m_ready.
  - rinc never asserts while rempty is high.
- Output and pop:
  - m_valid = (occ != 0). m_data = head entry.
  - Pop on m_valid && m_ready: head advances, occ decrements.
- Latency: read accepted in T → m_valid high in T+2. There is no bypass path from rdata to m_data.
- Throughput: with m_ready held high and the FIFO non-empty, rinc stays high continuously. One word is delivered per cycle after the 2-cycle fill.
- Simultaneous capture and pop in one cycle:
  - occ is unchanged.
  - Order is preserved: the popped word is the old head, and the captured word goes behind the remaining entry.
- Full buffer: occ=2 with m_ready=0 holds m_data/m_valid stable. No further rinc is issued. The buffer never overflows.
- Ordering: strict FIFO order from rdata to m_data. Entries are never duplicated or skipped.
- word_cnt: +1 per pop. Wraps from all-ones to 0. Unaffected by flush.
- flush (cycle F):
  - occ is cleared at the end of F.
  - Any read in flight during F (accepted in F-1) sets the drop flag; its data arriving in F is discarded.
  - rinc=0 during F.
  - No pop is counted in F, even if m_valid && m_ready.
  - m_valid=0 in F+1.
  - Normal reads resume in F+1.
- Reset mid-operation: all state returns to reset values immediately. Any rdata returned after reset release is ignored, because inflight was cleared.
- Both storage entries are registered; no combinational path from rdata to outputs.

Test Plan:
- Reset with FIFO holding 3 words → rinc=0, m_valid=0, word_cnt=0 while rrstn low. After release, rinc high in the first cycle.
- FIFO pre-filled with 0x11..0x18, m_ready=1 → first m_valid 2 cycles after the first rinc. Outputs 0x11..0x18 on consecutive cycles. word_cnt=8. rinc drops when rempty rises.
- Same 8 words, m_ready=0 for 10 cycles then 1 → rinc issued exactly twice before stall. m_data holds 0x11 stable. All 8 words then delivered in order.
- m_ready toggling 1,0,1,0 with a continuous source → no word lost or duplicated; occ never exceeds 2.
- flush asserted one cycle after a read of 0x22 is accepted, with 0x21 buffered → 0x21 and 0x22 both discarded. m_valid=0 next cycle. The next word delivered is 0x23.
- CNT_WIDTH=4, 17 words delivered → word_cnt reads 1 after wrap.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the asynchronous FIFO, running entirely in the rclk domain.
// It issues rinc from the FIFO status and absorbs the RAM's one-cycle registered
// read latency. Data is presented as a valid/ready stream from a 2-entry
// registered buffer. With m_ready held high it sustains one word per cycle.
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rclk,
  input  logic                 rrstn,
  input  logic                 rempty,
  input  logic [WIDTH-1:0]     rdata,
  output logic                 rinc,
  input  logic                 flush,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Buffer state: occ counts valid entries; ent0 is always the head.
  logic [1:0]       occ;
  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;

  // A read was accepted last cycle, so rdata carries a word this cycle.
  logic inflight_p1;
  // The word in flight during a flush has been discarded.
  logic drop_p1;

  logic       pop;
  logic       capture;
  logic [2:0] lvl;

  // A pop is never counted in a flush cycle, because the whole buffer is discarded anyway.
  assign pop = m_valid && m_ready && !flush;

  // The word in flight during a flush is dropped, and so is any word marked by the drop flag.
  assign capture = inflight_p1 && !flush && !drop_p1;

  // Entries committed after this cycle's pop, including the word still in flight.
  assign lvl = {1'b0, occ} + {2'b00, inflight_p1} - {2'b00, pop};

  // Request a read only if the result is certain to fit. rinc is held low in reset and during flush.
  always_comb begin
    rinc = rrstn && !rempty && !flush && (lvl < 3'd2);
  end

  // Stream outputs come straight from registered state; rdata has no bypass path to them.
  always_comb begin
    m_valid = (occ != 2'd0);
    m_data  = ent0;
  end

  // Control state: in-flight tracking, drop flag, occupancy and delivered-word counter.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      inflight_p1 <= 1'b0;
      drop_p1     <= 1'b0;
      occ         <= 2'd0;
      word_cnt    <= '0;
    end else begin
      inflight_p1 <= rinc;
      drop_p1     <= flush && inflight_p1;
      if (flush) begin
        occ <= 2'd0;
      end else begin
        case ({capture, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
      if (pop) begin
        word_cnt <= word_cnt + CNT_ONE;
      end
    end
  end

  // Storage entries: the head shifts forward on pop, and a captured word joins behind the remaining entries.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      ent0 <= '0;
      ent1 <= '0;
    end else if (!flush) begin
      case ({capture, pop})
        2'b11: begin
          if (occ == 2'd2) begin
            ent0 <= ent1;
            ent1 <= rdata;
          end else begin
            ent0 <= rdata;
          end
        end
        2'b01: begin
          ent0 <= ent1;
        end
        2'b10: begin
          if (occ == 2'd0) begin
            ent0 <= rdata;
          end else begin
            ent1 <= rdata;
          end
        end
        default: begin
          ent0 <= ent0;
          ent1 <= ent1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream. A FIFO model feeds words with one cycle of read
// latency. A queue-based reference tracks buffered words, in-flight words and
// the delivered count. Outputs are sampled on the falling edge.
module tb_fifo_rd_stream;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          rrstn = 1'b0;
  logic          rempty = 1'b1;
  logic [W-1:0]  rdata = '0;
  logic          rinc;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic [CW-1:0] word_cnt;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .rclk     (rclk),
    .rrstn    (rrstn),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .flush    (flush),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .word_cnt (word_cnt)
  );

  int tests  = 0;
  int failed = 0;

  byte unsigned src[$];        // words still inside the FIFO
  byte unsigned sent[$];       // words pushed into the FIFO during a phase
  byte unsigned mbuf[$];       // words the stream should currently hold, head first
  byte unsigned delivered[$];  // words popped from the stream during a phase
  bit           infl = 1'b0;
  byte unsigned infl_w = 8'h00;
  int           cnt_m = 0;
  int           cyc = 0;
  int           rinc_hi = 0;
  int           first_pop = -1;
  int           last_pop = -1;
  bit           s_valid;
  logic [W-1:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input byte unsigned w);
    src.push_back(w);
    sent.push_back(w);
    rempty = 1'b0;
  endtask

  task automatic do_reset();
    rrstn = 1'b0;
    mbuf.delete();
    infl  = 1'b0;
    cnt_m = 0;
  endtask

  // One clock cycle: check on the falling edge, then advance the reference model just after the rising edge.
  task automatic cycle();
    bit exp_rinc;
    bit mpop;
    bit acc;
    int lvl;
    @(negedge rclk);
    mpop = rrstn && (mbuf.size() != 0) && m_ready && !flush;
    lvl  = int'(mbuf.size()) + (infl ? 1 : 0) - (((mbuf.size() != 0) && m_ready) ? 1 : 0);
    exp_rinc = rrstn && !rempty && !flush && (lvl < 2);
    chk("rinc", rinc, exp_rinc);
    chk("m_valid", m_valid, mbuf.size() != 0);
    if (mbuf.size() != 0) chk("m_data", m_data, mbuf[0]);
    chk("word_cnt", word_cnt, cnt_m);
    s_valid = m_valid;
    s_data  = m_data;
    acc = rinc && !rempty;
    if (rinc) rinc_hi++;
    if (mpop) begin
      delivered.push_back(mbuf[0]);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    @(posedge rclk);
    #1;
    cyc++;
    if (mpop) begin
      mbuf.delete(0);
      cnt_m = (cnt_m + 1) % (1 << CW);
    end
    if (flush) mbuf.delete();
    if (infl && !flush && rrstn) mbuf.push_back(infl_w);
    if (acc) begin
      infl_w = src.pop_front();
      rdata  = infl_w;
      infl   = 1'b1;
    end else begin
      rdata = W'($urandom);
      infl  = 1'b0;
    end
    rempty = (src.size() == 0);
  endtask

  initial begin
    int start;

    // Reset with three words waiting in the FIFO.
    do_reset();
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (3) cycle();
    chk("rst_mdata", m_data, 8'h00);
    chk("rst_cnt", word_cnt, 4'd0);
    rrstn   = 1'b1;
    rinc_hi = 0;
    cycle();
    chk("rinc_after_release", rinc_hi, 1);
    m_ready = 1'b1;
    repeat (6) cycle();
    chk("rst_drain_n", delivered.size(), 3);

    // Throughput and latency at full rate.
    delivered.delete(); sent.delete();
    rinc_hi = 0; first_pop = -1;
    for (int i = 0; i < 8; i++) push(byte'(8'h11 + i));
    start = cyc;
    repeat (14) cycle();
    chk("thru_latency", first_pop - start, 2);
    chk("thru_rinc", rinc_hi, 8);
    chk("thru_n", delivered.size(), 8);
    chk("thru_span", last_pop - first_pop, 7);
    for (int i = 0; i < 8; i++) chk("thru_word", delivered[i], 8'h11 + i);
    chk("thru_cnt", word_cnt, 4'd11);

    // Stall with a full buffer, then release.
    delivered.delete(); sent.delete();
    m_ready = 1'b0; rinc_hi = 0;
    for (int i = 0; i < 8; i++) push(byte'(8'h11 + i));
    repeat (10) cycle();
    chk("stall_rinc", rinc_hi, 2);
    chk("stall_valid", s_valid, 1'b1);
    chk("stall_data", s_data, 8'h11);
    m_ready = 1'b1;
    repeat (12) cycle();
    chk("stall_n", delivered.size(), 8);
    for (int i = 0; i < 8; i++) chk("stall_word", delivered[i], 8'h11 + i);
    chk("wrap_cnt", word_cnt, 4'd3);

    // Alternating ready with a continuous source.
    delivered.delete(); sent.delete();
    for (int i = 0; i < 40; i++) begin
      if (src.size() < 3) push(byte'(8'h40 + i));
      m_ready = (i % 2) == 0;
      cycle();
    end
    m_ready = 1'b1;
    repeat (8) cycle();
    chk("toggle_n", delivered.size(), sent.size());
    for (int i = 0; i < delivered.size(); i++) chk("toggle_word", delivered[i], sent[i]);

    // Flush while 0x21 is buffered and 0x22 is in flight.
    delivered.delete(); sent.delete();
    m_ready = 1'b0;
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    cycle();
    cycle();
    flush = 1'b1;
    cycle();
    chk("flush_head", s_data, 8'h21);
    flush = 1'b0;
    cycle();
    chk("flush_valid", s_valid, 1'b0);
    m_ready = 1'b1;
    repeat (6) cycle();
    chk("flush_n", delivered.size(), 2);
    if (delivered.size() > 0) chk("flush_next", delivered[0], 8'h23);

    // Reset while a read is in flight.
    delivered.delete(); sent.delete();
    m_ready = 1'b0;
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    cycle();
    do_reset();
    cycle();
    cycle();
    rrstn   = 1'b1;
    m_ready = 1'b1;
    repeat (8) cycle();
    chk("midrst_n", delivered.size(), 3);
    if (delivered.size() > 0) chk("midrst_first", delivered[0], 8'h52);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 3) == 0) push(byte'($urandom));
      m_ready = ($urandom % 4) != 0;
      flush   = ($urandom % 25) == 0;
      cycle();
    end
    flush   = 1'b0;
    m_ready = 1'b1;
    repeat (300) cycle();
    chk("rand_drained", m_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
